// File: rtl/fetch_stage.sv
// fetch_stage: RV32 stage-1 fetch; owns the PC, one outstanding I$ request, registered f_* boundary. Optional FETCH_STATIC_PREDICT_EN.
// Latency: f_* valid the edge after the cache response; a zero-wait cache gives one instruction every 2 cycles.
// Backpressure: f_ready low holds f_* stable and blocks new requests; redirect_valid kills fetch in any state.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            icache_req_valid,
    output logic [XLEN-1:0] icache_req_addr,
    input  logic            icache_req_ready,
    input  logic            icache_resp_valid,
    input  logic [31:0]     icache_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            f_ready,
    output logic            f_valid,
    output logic [XLEN-1:0] f_pc,
    output logic [31:0]     f_inst,
    output logic            f_pred_taken
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            pred_taken;
    } fetch_out_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] redirect_tgt;
    logic            out_vld_q;
    fetch_out_t      out_q;
    logic            out_free;
    logic            load_out;
    logic            pred_taken;
    logic            unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Requests only go out when the output register will be empty, so a
    // response always lands in a free slot and no skid buffer is needed.
    assign out_free = !out_vld_q || f_ready;

`ifdef FETCH_STATIC_PREDICT_EN
    logic            is_jal;
    logic [XLEN-1:0] jal_imm;

    assign is_jal  = (icache_resp_data[6:0] == 7'b1101111);
    assign jal_imm = {{(XLEN-20){icache_resp_data[31]}}, icache_resp_data[19:12],
                      icache_resp_data[20], icache_resp_data[30:21], 1'b0};
    assign pred_taken = is_jal;
    assign next_pc    = is_jal ? (pc_q + jal_imm) : (pc_q + XLEN'(4));
`else
    assign pred_taken = 1'b0;
    assign next_pc    = pc_q + XLEN'(4);
`endif

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        load_out         = 1'b0;
        icache_req_valid = 1'b0;
        case (state_q)
            S_REQ: begin
                icache_req_valid = out_free && !redirect_valid && reset_n;
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end else if (icache_req_valid && icache_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = icache_resp_valid ? S_REQ : S_FLUSH;
                end else if (icache_resp_valid) begin
                    load_out = 1'b1;
                    pc_d     = next_pc;
                    state_d  = S_REQ;
                end
            end
            S_FLUSH: begin
                // The killed request's response is still owed; swallow it before refetching.
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (icache_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            if (redirect_valid) begin
                out_vld_q <= 1'b0;
            end else if (load_out) begin
                out_vld_q <= 1'b1;
            end else if (f_ready) begin
                out_vld_q <= 1'b0;
            end
            if (load_out) begin
                out_q.pc         <= pc_q;
                out_q.inst       <= icache_resp_data;
                out_q.pred_taken <= pred_taken;
            end
        end
    end

    assign icache_req_addr = pc_q;
    assign f_valid         = out_vld_q;
    assign f_pc            = out_q.pc;
    assign f_inst          = out_q.inst;
    assign f_pred_taken    = out_q.pred_taken;

    a_req_only_when_free: assert property (@(posedge clk) disable iff (!reset_n)
        icache_req_valid |-> out_free);
    a_req_addr_aligned: assert property (@(posedge clk) disable iff (!reset_n)
        icache_req_valid |-> (icache_req_addr[1:0] == 2'b00));
    a_resp_only_when_owed: assert property (@(posedge clk) disable iff (!reset_n)
        icache_resp_valid |-> (state_q != S_REQ));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a program-order PC model.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_2000;
`ifdef FETCH_STATIC_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        f_ready;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_inst;
    logic        f_pred_taken;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
        .icache_resp_data(icache_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .f_ready(f_ready), .f_valid(f_valid),
        .f_pc(f_pc), .f_inst(f_inst), .f_pred_taken(f_pred_taken)
    );

    // Synthetic program: mostly ALU ops, some JALs with known offsets.
    function automatic void gen_word(input logic [31:0] a, output logic [31:0] inst,
                                     output bit jal, output logic [31:0] tgt);
        logic [31:0] h;
        logic [20:0] o;
        int          off;
        h   = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        jal = (h[31:29] == 3'd0);
        case (h[28:27])
            2'd0:    off = 16;
            2'd1:    off = -8;
            2'd2:    off = 2048;
            default: off = -4096;
        endcase
        o   = off[20:0];
        tgt = a + off;
        if (jal) inst = {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
        else     inst = {h[24:0], 7'b0010011};
    endfunction

    task automatic idle_inputs();
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_data  = 32'h0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        f_ready           = 1'b0;
    endtask

    // Returns at the negedge on which reset_n is released.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        icache_req_ready = 1'b1;
        f_ready          = 1'b1;
        reset_n          = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (f_valid !== 1'b0 || f_pc !== 32'h0 || f_inst !== 32'h0 || f_pred_taken !== 1'b0)
            $display("FAIL reset_outputs: f_valid=%b f_pc=%h f_inst=%h pred=%b, want all zero",
                     f_valid, f_pc, f_inst, f_pred_taken);
        else n_pass++;
        n_checks++;
        if (icache_req_valid !== 1'b0)
            $display("FAIL reset_req_valid: got %b want 0", icache_req_valid);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== RESET_PC || f_valid !== 1'b0)
            $display("FAIL reset_release_req: valid=%b addr=%h f_valid=%b, want 1 %h 0",
                     icache_req_valid, icache_req_addr, f_valid, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_first_fetch();
        do_reset();
        icache_req_ready = 1'b1;
        f_ready          = 1'b1;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2000)
            $display("FAIL first_req: valid=%b addr=%h want 1 00002000", icache_req_valid, icache_req_addr);
        else n_pass++;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h0000_0013;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b0)
            $display("FAIL no_req_while_waiting: valid=%b want 0", icache_req_valid);
        else n_pass++;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (f_valid !== 1'b1 || f_pc !== 32'h2000 || f_inst !== 32'h13)
            $display("FAIL first_load: f_valid=%b f_pc=%h f_inst=%h want 1 00002000 00000013",
                     f_valid, f_pc, f_inst);
        else n_pass++;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2004)
            $display("FAIL second_req: valid=%b addr=%h want 1 00002004", icache_req_valid, icache_req_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        icache_req_ready = 1'b1;
        f_ready          = 1'b0;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = d;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        icache_resp_data  = ~d;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (icache_req_valid !== 1'b0 || f_valid !== 1'b1 || f_pc !== 32'h2000 || f_inst !== d)
                $display("FAIL stall_hold[%0d]: req=%b f_valid=%b f_pc=%h f_inst=%h want 0 1 00002000 %h",
                         i, icache_req_valid, f_valid, f_pc, f_inst, d);
            else n_pass++;
            @(negedge clk);
        end
        f_ready = 1'b1;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2004)
            $display("FAIL stall_release_req: valid=%b addr=%h want 1 00002004", icache_req_valid, icache_req_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        icache_req_ready = 1'b1;
        f_ready          = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b0)
            $display("FAIL flush_no_req: valid=%b want 0", icache_req_valid);
        else n_pass++;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h0010_0093;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (f_valid !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h3000)
            $display("FAIL flush_drop: f_valid=%b req=%b addr=%h want 0 1 00003000",
                     f_valid, icache_req_valid, icache_req_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_collide();
        do_reset();
        icache_req_ready = 1'b1;
        f_ready          = 1'b0;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h0020_0113;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        redirect_valid    = 1'b1;
        redirect_pc       = 32'h4002;
        #1;
        n_checks++;
        if (f_valid !== 1'b1 || icache_req_valid !== 1'b0)
            $display("FAIL collide_pre: f_valid=%b req=%b want 1 0", f_valid, icache_req_valid);
        else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (f_valid !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4000)
            $display("FAIL redirect_kills_held: f_valid=%b req=%b addr=%h want 0 1 00004000",
                     f_valid, icache_req_valid, icache_req_addr);
        else n_pass++;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h0030_0193;
        redirect_valid    = 1'b1;
        redirect_pc       = 32'h5000;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        redirect_valid    = 1'b0;
        #1;
        n_checks++;
        if (f_valid !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h5000)
            $display("FAIL redirect_with_resp: f_valid=%b req=%b addr=%h want 0 1 00005000",
                     f_valid, icache_req_valid, icache_req_addr);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        icache_req_ready = 1'b1;
        f_ready          = 1'b1;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'hDEAD_0013;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (f_valid !== 1'b1 || f_pc !== 32'h2000 || f_inst !== 32'hDEAD_0013)
            $display("FAIL async_pre_load: f_valid=%b f_pc=%h f_inst=%h want 1 00002000 dead0013",
                     f_valid, f_pc, f_inst);
        else n_pass++;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (f_valid !== 1'b0 || f_pc !== 32'h0 || f_inst !== 32'h0 || icache_req_valid !== 1'b0)
            $display("FAIL async_reset_outputs: f_valid=%b f_pc=%h f_inst=%h req=%b want all zero",
                     f_valid, f_pc, f_inst, icache_req_valid);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2000)
            $display("FAIL async_release_req: valid=%b addr=%h want 1 00002000", icache_req_valid, icache_req_addr);
        else n_pass++;
    endtask

    task automatic test_jal();
        logic [31:0] exp_addr;
        exp_addr = PRED ? 32'h2010 : 32'h2004;
        do_reset();
        icache_req_ready = 1'b1;
        f_ready          = 1'b1;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h0100_00EF;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (f_valid !== 1'b1 || f_pc !== 32'h2000 || f_pred_taken !== PRED)
            $display("FAIL jal_load: f_valid=%b f_pc=%h pred=%b want 1 00002000 %b",
                     f_valid, f_pc, f_pred_taken, PRED);
        else n_pass++;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== exp_addr)
            $display("FAIL jal_next_req: valid=%b addr=%h want 1 %h", icache_req_valid, icache_req_addr, exp_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        icache_req_ready = 1'b1;
        f_ready          = 1'b1;
        redirect_valid   = 1'b1;
        redirect_pc      = 32'hFFFF_FFFE;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b0)
            $display("FAIL redirect_blocks_req: valid=%b want 0", icache_req_valid);
        else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req: valid=%b addr=%h want 1 fffffffc", icache_req_valid, icache_req_addr);
        else n_pass++;
        @(negedge clk);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h0000_0013;
        @(negedge clk);
        icache_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (f_pc !== 32'hFFFF_FFFC || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0)
            $display("FAIL wrap_next: f_pc=%h req=%b addr=%h want fffffffc 1 00000000",
                     f_pc, icache_req_valid, icache_req_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, pend_addr, inst, tgt;
        bit          jal, pend;
        int          lat, consumed;
        bit          p_fv, p_fr, p_rd, p_rv, p_rr;
        logic [31:0] p_fpc, p_finst, p_addr;
        do_reset();
        exp_pc = RESET_PC;
        pend = 0; lat = 0; consumed = 0;
        p_fv = 0; p_fr = 0; p_rd = 0; p_rv = 0; p_rr = 0;
        p_fpc = 0; p_finst = 0; p_addr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            f_ready          = ($urandom_range(0, 3) != 0);
            icache_req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid   = ($urandom_range(0, 24) == 0);
            redirect_pc      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                           : (32'h2000 + 32'($urandom_range(0, 1023)));
            if (pend && lat == 0) begin
                gen_word(pend_addr, inst, jal, tgt);
                icache_resp_valid = 1'b1;
                icache_resp_data  = inst;
            end else begin
                icache_resp_valid = 1'b0;
                icache_resp_data  = $urandom;
                if (pend) lat--;
            end
            #1;
            if (p_fv && !p_fr && !p_rd) begin
                n_checks++;
                if (f_valid !== 1'b1 || f_pc !== p_fpc || f_inst !== p_finst)
                    $display("FAIL rnd_stall_stable cyc %0d: f_valid=%b f_pc=%h f_inst=%h want 1 %h %h",
                             cyc, f_valid, f_pc, f_inst, p_fpc, p_finst);
                else n_pass++;
            end
            if (p_rv && !p_rr && !p_rd && icache_req_valid) begin
                n_checks++;
                if (icache_req_addr !== p_addr)
                    $display("FAIL rnd_addr_stable cyc %0d: addr=%h want %h", cyc, icache_req_addr, p_addr);
                else n_pass++;
            end
            if (icache_req_valid) begin
                n_checks++;
                if (pend || (f_valid && !f_ready) || redirect_valid)
                    $display("FAIL rnd_req_legal cyc %0d: req=1 outstanding=%b f_valid=%b f_ready=%b redirect=%b",
                             cyc, pend, f_valid, f_ready, redirect_valid);
                else n_pass++;
            end
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (f_valid && f_ready) begin
                gen_word(exp_pc, inst, jal, tgt);
                n_checks++;
                if (f_pc !== exp_pc || f_inst !== inst || f_pred_taken !== (PRED && jal))
                    $display("FAIL rnd_consume cyc %0d: f_pc=%h f_inst=%h pred=%b want %h %h %b",
                             cyc, f_pc, f_inst, f_pred_taken, exp_pc, inst, PRED && jal);
                else n_pass++;
                exp_pc   = (PRED && jal) ? tgt : exp_pc + 32'd4;
                consumed++;
            end
            if (icache_resp_valid) pend = 0;
            if (icache_req_valid && icache_req_ready) begin
                pend      = 1;
                pend_addr = icache_req_addr;
                lat       = $urandom_range(0, 2);
            end
            p_fv = f_valid; p_fr = f_ready; p_rd = redirect_valid;
            p_rv = icache_req_valid; p_rr = icache_req_ready;
            p_fpc = f_pc; p_finst = f_inst; p_addr = icache_req_addr;
        end
        n_checks++;
        if (consumed < 100)
            $display("FAIL rnd_progress: consumed %0d instructions, want at least 100", consumed);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_collide();
        test_async_reset();
        test_jal();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
